// File: rtl/perceptron_update.sv
// perceptron_update: one training step for a two-input threshold perceptron.
// A start in IDLE captures the sample and current weights. Two cycles of
// multiply-accumulate on one shared multiplier form the net input. ACT
// applies the threshold, and UPD presents the corrected weights with a load
// strobe when the sample was misclassified.
//
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   start, init            step request / weight-clear request (IDLE only)
//   x1, x2, t              sample inputs and target class (1 = +1, 0 = -1)
//   alpha, theta           learning rate, activation threshold (>= 0)
//   w1, w2, b              current weight/bias register contents
//   w1_new, w2_new, b_new  update values, valid while ld_w is high
//   ld_w, init0_w          load / clear strobes for the weight registers
//   y, err                 activation (-1/0/+1) and misclassification flag
//   busy, done             step in progress / one-cycle completion pulse
module perceptron_update #(
   parameter int unsigned N = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                init,
   input  logic signed [N-1:0] x1,
   input  logic signed [N-1:0] x2,
   input  logic                t,
   input  logic signed [N-1:0] alpha,
   input  logic signed [N-1:0] theta,
   input  logic signed [N-1:0] w1,
   input  logic signed [N-1:0] w2,
   input  logic signed [N-1:0] b,
   output logic signed [N-1:0] w1_new,
   output logic signed [N-1:0] w2_new,
   output logic signed [N-1:0] b_new,
   output logic                ld_w,
   output logic                init0_w,
   output logic signed [1:0]   y,
   output logic                busy,
   output logic                done,
   output logic                err
);

   localparam int unsigned PW = 2 * N;      // full product width
   localparam int unsigned SW = 2 * N + 1;  // update sum width before wrap
   localparam int unsigned AW = 2 * N + 2;  // accumulator width

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_MAC1 = 3'd1;
   localparam logic [2:0] S_MAC2 = 3'd2;
   localparam logic [2:0] S_ACT  = 3'd3;
   localparam logic [2:0] S_UPD  = 3'd4;

   logic [2:0] state, state_nxt;
   logic       armed;
   logic       accept_c;

   logic signed [N-1:0]  x1_r, x2_r, alpha_r, theta_r, w1_r, w2_r, b_r;
   logic                 t_r;
   logic signed [AW-1:0] acc;

   logic signed [N-1:0]  mul_a, mul_b;
   logic signed [PW-1:0] prod;
   logic signed [AW-1:0] theta_ext;
   logic signed [1:0]    y_c, tgt_c;
   logic                 err_c;
   logic signed [PW-1:0] d1, d2;
   logic signed [SW-1:0] s1, s2, sb;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic; init has priority over start in IDLE
   always_comb begin
      state_nxt = state;
      accept_c  = 1'b0;
      case (state)
         S_IDLE: begin
            if (start && !init) begin
               accept_c  = 1'b1;
               state_nxt = S_MAC1;
            end
         end
         S_MAC1:  state_nxt = S_MAC2;
         S_MAC2:  state_nxt = S_ACT;
         S_ACT:   state_nxt = S_UPD;
         S_UPD:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Keeps init0_w low in the first cycle after reset release
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) armed <= 1'b0;
      else      armed <= 1'b1;
   end

   assign busy    = (state != S_IDLE);
   assign init0_w = (state == S_IDLE) && init && armed;

   // Sample capture so later input changes during busy have no effect
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x1_r    <= '0;
         x2_r    <= '0;
         t_r     <= 1'b0;
         alpha_r <= '0;
         theta_r <= '0;
         w1_r    <= '0;
         w2_r    <= '0;
         b_r     <= '0;
      end else if (accept_c) begin
         x1_r    <= x1;
         x2_r    <= x2;
         t_r     <= t;
         alpha_r <= alpha;
         theta_r <= theta;
         w1_r    <= w1;
         w2_r    <= w2;
         b_r     <= b;
      end
   end

   // Shared multiplier: w1*x1 in MAC1, w2*x2 in MAC2
   always_comb begin
      mul_a = w1_r;
      mul_b = x1_r;
      if (state == S_MAC2) begin
         mul_a = w2_r;
         mul_b = x2_r;
      end
   end

   assign prod = PW'(mul_a) * PW'(mul_b);

   // Net-input accumulator
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc <= '0;
      end else if (state == S_MAC1) begin
         acc <= AW'(b_r) + AW'(prod);
      end else if (state == S_MAC2) begin
         acc <= acc + AW'(prod);
      end
   end

   // Threshold activation with a dead zone of [-theta, theta]
   assign theta_ext = AW'(theta_r);
   always_comb begin
      y_c = 2'sb00;
      if (acc > theta_ext)       y_c = 2'sb01;
      else if (acc < -theta_ext) y_c = 2'sb11;
   end

   assign tgt_c = t_r ? 2'sb01 : 2'sb11;
   assign err_c = (y_c != tgt_c);

   // Weight corrections: full-width products, sum wrapped to N bits
   assign d1 = PW'(alpha_r) * PW'(x1_r);
   assign d2 = PW'(alpha_r) * PW'(x2_r);
   assign s1 = t_r ? (SW'(w1_r) + SW'(d1)) : (SW'(w1_r) - SW'(d1));
   assign s2 = t_r ? (SW'(w2_r) + SW'(d2)) : (SW'(w2_r) - SW'(d2));
   assign sb = t_r ? (SW'(b_r) + SW'(alpha_r)) : (SW'(b_r) - SW'(alpha_r));

   // Registered results; captured in ACT so they are visible during UPD
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         y      <= 2'sb00;
         err    <= 1'b0;
         ld_w   <= 1'b0;
         done   <= 1'b0;
         w1_new <= '0;
         w2_new <= '0;
         b_new  <= '0;
      end else begin
         ld_w <= 1'b0;
         done <= 1'b0;
         if (state == S_ACT) begin
            y      <= y_c;
            err    <= err_c;
            ld_w   <= err_c;
            done   <= 1'b1;
            w1_new <= N'(s1);
            w2_new <= N'(s2);
            b_new  <= N'(sb);
         end
      end
   end

endmodule

// File: tb/tb_perceptron_update.sv
// tb_perceptron_update: directed-vector bench for perceptron_update (N=16).
module tb_perceptron_update;

   localparam int unsigned N = 16;
   localparam logic signed [1:0] YP = 2'sb01;
   localparam logic signed [1:0] YZ = 2'sb00;
   localparam logic signed [1:0] YN = 2'sb11;

   logic                clk, rst, start, init, t;
   logic signed [N-1:0] x1, x2, alpha, theta, w1, w2, b;
   logic signed [N-1:0] w1_new, w2_new, b_new;
   logic                ld_w, init0_w, busy, done, err;
   logic signed [1:0]   y;

   int n_tests = 0;
   int n_fail  = 0;

   perceptron_update #(.N(N)) dut (
      .clk(clk), .rst(rst), .start(start), .init(init),
      .x1(x1), .x2(x2), .t(t), .alpha(alpha), .theta(theta),
      .w1(w1), .w2(w2), .b(b),
      .w1_new(w1_new), .w2_new(w2_new), .b_new(b_new),
      .ld_w(ld_w), .init0_w(init0_w), .y(y),
      .busy(busy), .done(done), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One training step; start a stray pulse in MAC2 and scramble inputs while busy
   task automatic run_step(input string tag,
                           input logic signed [N-1:0] iw1, iw2, ib, ix1, ix2,
                           input logic it,
                           input logic signed [N-1:0] ialpha, itheta,
                           input logic signed [1:0] ey, input logic eerr,
                           input logic signed [N-1:0] ew1, ew2, eb);
      w1 = iw1; w2 = iw2; b = ib; x1 = ix1; x2 = ix2; t = it;
      alpha = ialpha; theta = itheta; start = 1'b1;
      tick();                                  // MAC1
      start = 1'b0;
      w1 = 16'sh1234; x1 = -16'sd77; b = 16'sd999; alpha = 16'sd5;
      check({tag, ".busy_mac1"}, 16'(busy), 16'd1);
      tick();                                  // MAC2
      start = 1'b1;
      x2 = 16'sd300; w2 = -16'sd9; t = ~it;
      tick();                                  // ACT
      start = 1'b0;
      check({tag, ".done_act"}, 16'(done), 16'd0);
      tick();                                  // UPD
      check({tag, ".done"}, 16'(done), 16'd1);
      check({tag, ".ld_w"}, 16'(ld_w), 16'(eerr));
      check({tag, ".y"}, 16'(y), 16'(ey));
      check({tag, ".err"}, 16'(err), 16'(eerr));
      if (eerr) begin
         check({tag, ".w1_new"}, w1_new, ew1);
         check({tag, ".w2_new"}, w2_new, ew2);
         check({tag, ".b_new"}, b_new, eb);
      end
      tick();                                  // IDLE
      check({tag, ".done_pulse"}, 16'(done), 16'd0);
      check({tag, ".ld_pulse"}, 16'(ld_w), 16'd0);
      check({tag, ".busy_idle"}, 16'(busy), 16'd0);
      check({tag, ".y_hold"}, 16'(y), 16'(ey));
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; init = 1'b0; t = 1'b0;
      x1 = '0; x2 = '0; alpha = '0; theta = '0; w1 = '0; w2 = '0; b = '0;
      tick(); tick();
      check("rst.busy", 16'(busy), 16'd0);
      check("rst.done", 16'(done), 16'd0);
      check("rst.ld_w", 16'(ld_w), 16'd0);
      check("rst.init0_w", 16'(init0_w), 16'd0);
      check("rst.y", 16'(y), 16'(YZ));

      rst = 1'b1; init = 1'b1;
      #1;
      check("rel.init0_w_first", 16'(init0_w), 16'd0);
      check("rel.busy_first", 16'(busy), 16'd0);
      tick();
      check("rel.init0_w", 16'(init0_w), 16'd1);
      init = 1'b0;
      #1;
      check("rel.init0_w_off", 16'(init0_w), 16'd0);

      // net 0 -> y 0, target +1
      run_step("zero_net", 16'sd0, 16'sd0, 16'sd0, 16'sd1, 16'sd1, 1'b1, 16'sd1, 16'sd0,
               YZ, 1'b1, 16'sd1, 16'sd1, 16'sd1);
      // net 3 -> correct
      run_step("correct", 16'sd1, 16'sd1, 16'sd1, 16'sd1, 16'sd1, 1'b1, 16'sd1, 16'sd0,
               YP, 1'b0, 16'sd0, 16'sd0, 16'sd0);
      // net 1, target -1
      run_step("neg_t", 16'sd1, 16'sd1, 16'sd1, 16'sd1, -16'sd1, 1'b0, 16'sd1, 16'sd0,
               YP, 1'b1, 16'sd0, 16'sd2, 16'sd0);
      // same with dead zone theta 5
      run_step("dead_zone", 16'sd1, 16'sd1, 16'sd1, 16'sd1, -16'sd1, 1'b0, 16'sd1, 16'sd5,
               YZ, 1'b1, 16'sd0, 16'sd2, 16'sd0);
      // 32767 + 1 wraps; theta 32767 keeps net 32767 in the dead zone
      run_step("wrap", 16'sh7FFF, 16'sd0, 16'sd0, 16'sd1, 16'sd0, 1'b1, 16'sd1, 16'sh7FFF,
               YZ, 1'b1, 16'sh8000, 16'sd0, 16'sd1);
      // net 50+300-400 = -50 < -10, target +1, alpha 2
      run_step("neg_net", 16'sd100, -16'sd200, 16'sd50, 16'sd3, 16'sd2, 1'b1, 16'sd2, 16'sd10,
               YN, 1'b1, 16'sd106, -16'sd196, 16'sd52);
      // same sample, target -1 -> correct
      run_step("neg_ok", 16'sd100, -16'sd200, 16'sd50, 16'sd3, 16'sd2, 1'b0, 16'sd2, 16'sd10,
               YN, 1'b0, 16'sd0, 16'sd0, 16'sd0);

      // init and start together: clear wins, no step begins
      init = 1'b1; start = 1'b1;
      #1;
      check("both.init0_w", 16'(init0_w), 16'd1);
      tick();
      init = 1'b0; start = 1'b0;
      check("both.busy", 16'(busy), 16'd0);
      tick();
      check("both.busy2", 16'(busy), 16'd0);
      check("both.done", 16'(done), 16'd0);

      // reset asserted in ACT
      w1 = 16'sd0; w2 = 16'sd0; b = 16'sd0; x1 = 16'sd1; x2 = 16'sd1;
      t = 1'b1; alpha = 16'sd1; theta = 16'sd0; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();                          // ACT
      rst = 1'b0;
      #1;
      check("rst_act.busy", 16'(busy), 16'd0);
      check("rst_act.y", 16'(y), 16'(YZ));
      check("rst_act.err", 16'(err), 16'd0);
      tick();
      check("rst_act.ld_w", 16'(ld_w), 16'd0);
      check("rst_act.done", 16'(done), 16'd0);
      rst = 1'b1;
      #1;
      check("rst_act.busy_rel", 16'(busy), 16'd0);
      tick();
      check("rst_act.ld_w_rel", 16'(ld_w), 16'd0);
      run_step("after_rst", 16'sd1, 16'sd1, 16'sd1, 16'sd1, 16'sd1, 1'b1, 16'sd1, 16'sd0,
               YP, 1'b0, 16'sd0, 16'sd0, 16'sd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
